// File: rtl/water_level_ctrl.sv
// Water level selector and fill/drain valve sequencer for the washer controller.
// Tracks a modelled water level and pulses fill_done/drain_done for the wash sequencer.
module water_level_ctrl #(
  parameter int W             = 3,
  parameter int MIN_LEVEL     = 2,
  parameter int MAX_LEVEL     = 5,
  parameter int DEFAULT_LEVEL = 2,
  parameter int FILL_TICKS    = 4,
  parameter int DRAIN_TICKS   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         power_light,
  input  logic         finish,
  input  logic [1:0]   run_state,
  input  logic         level_up,
  input  logic         level_down,
  input  logic         fill_req,
  input  logic         drain_req,
  output logic [W-1:0] target_level,
  output logic [W-1:0] water_now,
  output logic         fill_valve,
  output logic         drain_valve,
  output logic         fill_done,
  output logic         drain_done
);

  localparam int MAX_TICKS = (FILL_TICKS > DRAIN_TICKS) ? FILL_TICKS : DRAIN_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [W-1:0]  L_MIN      = W'(MIN_LEVEL);
  localparam logic [W-1:0]  L_MAX      = W'(MAX_LEVEL);
  localparam logic [W-1:0]  L_DEF      = W'(DEFAULT_LEVEL);
  localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_TICKS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TICKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

  state_t        r_state;
  logic [W-1:0]  r_target;
  logic [W-1:0]  r_water;
  logic [CW-1:0] r_cnt;
  logic          r_upPrev;
  logic          r_downPrev;
  logic          r_fillValve;
  logic          r_drainValve;
  logic          r_fillDone;
  logic          r_drainDone;

  logic          w_upEvt;
  logic          w_downEvt;
  logic          w_running;
  logic          w_idleRun;
  logic [W-1:0]  w_waterInc;
  logic [W-1:0]  w_waterDec;

  assign w_upEvt    = level_up & ~r_upPrev;
  assign w_downEvt  = level_down & ~r_downPrev;
  assign w_running  = (run_state == 2'b01);
  assign w_idleRun  = (run_state == 2'b00);
  assign w_waterInc = r_water + 1'b1;
  assign w_waterDec = r_water - 1'b1;

  // Target selection: power loss or wash completion restores the preset level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target   <= L_DEF;
      r_upPrev   <= 1'b0;
      r_downPrev <= 1'b0;
    end else begin
      r_upPrev   <= level_up;
      r_downPrev <= level_down;
      if (!power_light || finish) begin
        r_target <= L_DEF;
      end else if (w_idleRun) begin
        if (w_upEvt && !w_downEvt) begin
          r_target <= (r_target == L_MAX) ? L_MIN : r_target + 1'b1;
        end else if (w_downEvt && !w_upEvt) begin
          r_target <= (r_target == L_MIN) ? L_MAX : r_target - 1'b1;
        end
      end
    end
  end

  // Valves and done pulses default low each cycle; a paused FILL/DRAIN simply holds state and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_water      <= '0;
      r_cnt        <= '0;
      r_fillValve  <= 1'b0;
      r_drainValve <= 1'b0;
      r_fillDone   <= 1'b0;
      r_drainDone  <= 1'b0;
    end else begin
      r_fillValve  <= 1'b0;
      r_drainValve <= 1'b0;
      r_fillDone   <= 1'b0;
      r_drainDone  <= 1'b0;
      if (!power_light) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_running) begin
              if (drain_req && (r_water != '0)) begin
                r_state      <= DRAIN;
                r_cnt        <= '0;
                r_drainValve <= 1'b1;
              end else if (fill_req && (r_water < r_target)) begin
                r_state     <= FILL;
                r_cnt       <= '0;
                r_fillValve <= 1'b1;
              end
            end
          end
          FILL: begin
            if (w_idleRun) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (w_running) begin
              if (drain_req) begin
                r_cnt <= '0;
                if (r_water != '0) begin
                  r_state      <= DRAIN;
                  r_drainValve <= 1'b1;
                end else begin
                  r_state <= IDLE;
                end
              end else if (r_cnt == FILL_LAST) begin
                r_cnt   <= '0;
                r_water <= w_waterInc;
                // >= guards against a target lowered by finish mid-fill
                if (w_waterInc >= r_target) begin
                  r_state    <= FULL;
                  r_fillDone <= 1'b1;
                end else begin
                  r_fillValve <= 1'b1;
                end
              end else begin
                r_cnt       <= r_cnt + 1'b1;
                r_fillValve <= 1'b1;
              end
            end
          end
          FULL: begin
            if (w_running && drain_req) begin
              r_state      <= DRAIN;
              r_cnt        <= '0;
              r_drainValve <= 1'b1;
            end
          end
          DRAIN: begin
            if (w_idleRun) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (w_running) begin
              if (r_cnt == DRAIN_LAST) begin
                r_cnt   <= '0;
                r_water <= w_waterDec;
                if (w_waterDec == '0) begin
                  r_state     <= IDLE;
                  r_drainDone <= 1'b1;
                end else begin
                  r_drainValve <= 1'b1;
                end
              end else begin
                r_cnt        <= r_cnt + 1'b1;
                r_drainValve <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign target_level = r_target;
  assign water_now    = r_water;
  assign fill_valve   = r_fillValve;
  assign drain_valve  = r_drainValve;
  assign fill_done    = r_fillDone;
  assign drain_done   = r_drainDone;

endmodule

// File: doc/water_level_ctrl.md
Name: water_level_ctrl

Overview:
Parametrised successor to the single-button water-amount selector in the washer controller.
- Selects a target water level with separate up and down buttons; both wrap between configurable MIN and MAX levels.
- Once the run starts, sequences the fill and drain valves and tracks the modelled water level.
- Sits between the panel/run-state logic and the valve drivers; raises one-cycle done pulses for the wash sequencer.

Parameters:
W, 3, width of the level fields.
MIN_LEVEL, 2, lowest selectable level (must be >= 1).
MAX_LEVEL, 5, highest selectable level (must be <= 2^W-1 and >= MIN_LEVEL).
DEFAULT_LEVEL, 2, preset level (MIN_LEVEL <= DEFAULT_LEVEL <= MAX_LEVEL).
FILL_TICKS, 4, clocks per one-unit level rise while filling (>= 1).
DRAIN_TICKS, 2, clocks per one-unit level fall while draining (>= 1).

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  asynchronous, active-low reset.
power_light  in  1  1 = powered.
finish  in  1  1 = wash cycle complete.
run_state  in  2  00 idle, 01 running, 10 paused, 11 treated as paused.
level_up  in  1  up button, level; the rising edge is the event.
level_down  in  1  down button, level; the rising edge is the event.
fill_req  in  1  sequencer requests fill (level).
drain_req  in  1  sequencer requests drain (level).
target_level  out  W  selected level.
water_now  out  W  modelled current water level.
fill_valve  out  1  fill valve open.
drain_valve  out  1  drain valve open.
fill_done  out  1  one-cycle pulse: water_now reached target_level.
drain_done  out  1  one-cycle pulse: water_now reached 0.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset values:
  - target_level = DEFAULT_LEVEL; water_now = 0.
  - Valves off; done pulses 0.
  - FSM in IDLE; tick counter 0; button edge registers 0.
- Edge detection:
  - Registered copies of level_up and level_down are updated every cycle regardless of mode.
  - An event is a current-1 / previous-0 pair; a held button produces exactly one event.
- Selection:
  - Priority 1: if power_light=0 or finish=1, target_level <= DEFAULT_LEVEL.
  - Priority 2: otherwise, only when run_state=00:
    - up event alone: target == MAX_LEVEL ? MIN_LEVEL : target+1.
    - down event alone: target == MIN_LEVEL ? MAX_LEVEL : target-1.
    - up and down events in the same cycle: ignored.
  - In all other run states, target_level is held.
- FSM states are IDLE, FILL, FULL, DRAIN; the tick counter is sized for max(FILL_TICKS, DRAIN_TICKS).
  - IDLE: valves off. Go to FILL when run_state=01, fill_req=1 and water_now < target_level. drain_req=1 with water_now > 0 goes to DRAIN. Requests made outside run_state=01 are ignored.
  - FILL: fill_valve=1. Tick counter counts 0..FILL_TICKS-1. At FILL_TICKS-1 it clears and water_now increments. When the new value equals target_level, go to FULL and pulse fill_done that same cycle. drain_req=1 goes to DRAIN with the counter cleared; drain has priority over fill.
  - FULL: valves off, water_now held. drain_req=1 with run_state=01 goes to DRAIN.
  - DRAIN: drain_valve=1. Counter counts to DRAIN_TICKS-1, then water_now decrements. When it reaches 0, go to IDLE and pulse drain_done.
- Pause (run_state=10 or 11) in FILL or DRAIN: valves forced off, counter frozen, state held. Resume on return to 01.
- run_state=00 while in FILL or DRAIN: go to IDLE, valves off, counter cleared, water_now held.
- power_light=0 at any time: FSM goes to IDLE, valves off, counter cleared, water_now held (physical water remains).
- finish=1: target reset only; the FSM is unaffected, so a final drain can complete.
- Valves are registered outputs; fill_valve and drain_valve are never both 1.
- water_now never exceeds MAX_LEVEL and never underflows below 0.

Test Plan:
1. Reset, power_light=1, run_state=00, four level_up pulses -> target_level 3, 4, 5, then 2 (wrap); a button held for 10 cycles -> exactly one step.
2. Target 2, one level_down pulse -> target 5; level_up and level_down rising in the same cycle -> target unchanged.
3. Target 4, run_state=01, fill_req=1 -> fill_valve high for 16 cycles; water_now steps 1, 2, 3, 4 every 4 clocks; fill_done pulses once; state FULL, valve off.
4. Mid-fill at water_now=2, run_state=10 for 7 cycles -> valve off and level frozen. On resume, the remaining ticks continue with no lost or extra count; FULL is reached 7 cycles later than without the pause.
5. In FULL at level 4, drain_req=1 -> drain_valve high for 8 cycles; water_now 3, 2, 1, 0; drain_done pulses; state IDLE. finish=1 during the drain -> target 2 while the drain completes.
6. During FILL: power_light=0 -> valves off next clock, target 2, water_now held. rst_n asserted mid-drain -> all outputs to reset values immediately, without waiting for a clock.
